// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset sequencing, lock qualification and PMA/PCS reset release
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 10000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             soft_reset,
    input  logic             pll_locked,
    output logic             pll_reset,
    output logic             pma_reset,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int PH_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int PH_MAX   = (PH_MAX_A > STABLE_CYCLES) ? PH_MAX_A : STABLE_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  TMO_LAST = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  STB_LAST = PH_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    logic            locked_meta;
    logic            locked_s;
    state_t          state_r;
    state_t          state_nxt;
    logic [PH_W-1:0] phase_cnt;
    logic            tmo_evt;
    logic            lost_evt;

    // pll_locked is asynchronous to clk_in; only locked_s is used below
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    always_comb begin
        state_nxt = state_r;
        tmo_evt   = 1'b0;
        lost_evt  = 1'b0;
        if (soft_reset) begin
            state_nxt = RESET_PLL;
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (phase_cnt == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (phase_cnt == TMO_LAST) begin
                        state_nxt = RESET_PLL;
                        tmo_evt   = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s)                  state_nxt = WAIT_LOCK;
                    else if (phase_cnt == STB_LAST) state_nxt = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = RESET_PLL;
                        lost_evt  = 1'b1;
                    end
                end
                default: state_nxt = RESET_PLL;
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as state
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= RESET_PLL;
            pll_reset <= 1'b1;
            pma_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            pll_reset <= (state_nxt == RESET_PLL);
            pma_reset <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
        end
    end

    // A soft reset restarts the RESET_PLL window even when already in RESET_PLL
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
        end else if (soft_reset || (state_nxt != state_r)) begin
            phase_cnt <= '0;
        end else if (state_r != RUN) begin
            phase_cnt <= phase_cnt + PH_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt   <= '0;
            lock_lost_cnt <= '0;
        end else begin
            if (tmo_evt && (timeout_cnt != CNT_SAT))
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            if (lost_evt && (lock_lost_cnt != CNT_SAT))
                lock_lost_cnt <= lock_lost_cnt + CNT_W'(1);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - scoreboard bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 2;

    logic             clk_in     = 1'b0;
    logic             reset_n    = 1'b0;
    logic             soft_reset = 1'b0;
    logic             pll_locked = 1'b0;
    logic             pll_reset;
    logic             pma_reset;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] lock_lost_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int b;

    string       sb_tag[$];
    int          sb_edge[$];
    logic [31:0] sb_exp[$];

    logic [31:0] obs;

    pll_reset_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .soft_reset   (soft_reset),
        .pll_locked   (pll_locked),
        .pll_reset    (pll_reset),
        .pma_reset    (pma_reset),
        .ready        (ready),
        .state        (state),
        .timeout_cnt  (timeout_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    // {pll_reset, pma_reset, ready, state, timeout_cnt, lock_lost_cnt}
    assign obs = {23'd0, pll_reset, pma_reset, ready, state, timeout_cnt, lock_lost_cnt};

    function automatic logic [31:0] mk(input logic [1:0] st, input int tc, input int lc);
        logic [1:0] tcv;
        logic [1:0] lcv;
        tcv = tc[1:0];
        lcv = lc[1:0];
        return {23'd0, (st == 2'd0), (st != 2'd3), (st == 2'd3), st, tcv, lcv};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got[8:0], exp[8:0]);
        end
    endtask

    task automatic push_span(input string tag, input int first, input int last,
                             input logic [1:0] st, input int tc, input int lc);
        for (int e = first; e <= last; e++) begin
            sb_tag.push_back(tag);
            sb_edge.push_back(e);
            sb_exp.push_back(mk(st, tc, lc));
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    always @(negedge clk_in) begin
        while (sb_edge.size() > 0 && sb_edge[0] <= edge_cnt) begin
            check($sformatf("%s@%0d", sb_tag[0], sb_edge[0]), obs, sb_exp[0]);
            void'(sb_tag.pop_front());
            void'(sb_edge.pop_front());
            void'(sb_exp.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1);
    end

    initial begin
        // Test 1: no lock, repeated timeouts with saturating count
        push_span("rst", 1, 2, 2'd0, 0, 0);
        b = 2;
        push_span("t1_rst", b + 1, b + 3, 2'd0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            push_span("t1_wait", b + 36*j + 4, b + 36*j + 35, 2'd1, j, 0);
            push_span("t1_rst", b + 36*(j+1), b + 36*(j+1) + 3, 2'd0, (j + 1 > 3) ? 3 : j + 1, 0);
        end
        push_span("t1_wait", b + 148, b + 150, 2'd1, 3, 0);
        wait_edge(2);
        reset_n = 1'b1;

        // async reset between edges clears saturated counter immediately
        wait_edge(152);
        #6;
        reset_n = 1'b0;
        #1;
        check("t1_async_rst", obs, mk(2'd0, 0, 0));
        push_span("rst", 153, 153, 2'd0, 0, 0);
        wait_edge(153);
        reset_n = 1'b1;

        // Test 2: lock 10 cycles into WAIT_LOCK
        push_span("t2_rst",    154, 156, 2'd0, 0, 0);
        push_span("t2_wait",   157, 168, 2'd1, 0, 0);
        push_span("t2_stable", 169, 176, 2'd2, 0, 0);
        push_span("t2_run",    177, 180, 2'd3, 0, 0);
        // Test 4 then test 3 on the relock path
        push_span("t4_run",    181, 182, 2'd3, 0, 0);
        push_span("t4_rst",    183, 186, 2'd0, 0, 1);
        push_span("t4_wait",   187, 187, 2'd1, 0, 1);
        push_span("t3_stable", 188, 194, 2'd2, 0, 1);
        push_span("t3_wait",   195, 197, 2'd1, 0, 1);
        push_span("t3_stable", 198, 205, 2'd2, 0, 1);
        push_span("t3_run",    206, 210, 2'd3, 0, 1);
        // Test 5: soft reset overriding lock loss and timeout
        push_span("t5_rst",    211, 214, 2'd0, 0, 1);
        push_span("t5_wait",   215, 246, 2'd1, 0, 1);
        push_span("t5_rst",    247, 250, 2'd0, 0, 1);
        push_span("t5_wait",   251, 253, 2'd1, 0, 1);
        push_span("t5_stable", 254, 261, 2'd2, 0, 1);
        push_span("t5_run",    262, 265, 2'd3, 0, 1);

        wait_edge(166);
        pll_locked = 1'b1;
        wait_edge(180);
        pll_locked = 1'b0;
        wait_edge(182);
        pll_locked = 1'b1;
        wait_edge(192);
        pll_locked = 1'b0;
        wait_edge(195);
        pll_locked = 1'b1;

        wait_edge(208);
        pll_locked = 1'b0;
        wait_edge(210);
        soft_reset = 1'b1;
        wait_edge(211);
        soft_reset = 1'b0;
        wait_edge(246);
        soft_reset = 1'b1;
        wait_edge(247);
        soft_reset = 1'b0;
        wait_edge(251);
        pll_locked = 1'b1;

        // Test 6: async reset mid-RUN
        wait_edge(265);
        #6;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        #1;
        check("t6_async_rst", obs, mk(2'd0, 0, 0));
        push_span("t6_rst", 266, 266, 2'd0, 0, 0);
        wait_edge(266);
        reset_n = 1'b1;
        push_span("t6_rst",  267, 269, 2'd0, 0, 0);
        push_span("t6_wait", 270, 272, 2'd1, 0, 0);

        wait_edge(274);
        check("sb_drain", 32'(sb_edge.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
